// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 cracking controller and its guess source.
package md5_pkg;
  localparam int MD5_MAX_LEN = 8;
  localparam logic [7:0] ASCII_A = 8'h61;
  localparam logic [7:0] ASCII_Z = 8'h7A;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/md5_guess_generator_char_digit.sv
// One odometer position: adds its stride when carried into, reloads on passing 'z'.
import md5_pkg::*;

module char_digit (
  input  logic [7:0] cur,
  input  logic [7:0] stride,
  input  logic [7:0] reload,
  input  logic       carry_in,
  output logic [7:0] nxt,
  output logic       carry_out
);
  logic [8:0] sum;
  logic       wrap;

  // 9-bit sum so a large stride never wraps through 0xFF back into range
  assign sum       = {1'b0, cur} + {1'b0, stride};
  assign wrap      = sum > {1'b0, ASCII_Z};
  assign nxt       = !carry_in ? cur : (wrap ? reload : sum[7:0]);
  assign carry_out = carry_in & wrap;
endmodule

// File: rtl/md5_guess_generator.sv
// Enumerates lowercase guesses in odometer order and offers them over valid/ready.
module md5_guess_generator
  import md5_pkg::*;
#(
  parameter int MAX_LEN = MD5_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           starting_position,
  input  logic [2:0]           increment,
  input  logic                 found,
  input  logic                 guess_ready,
  output logic                 guess_valid,
  output logic [8*MAX_LEN-1:0] guess,
  output logic [LEN_W-1:0]     guess_len,
  output logic                 busy,
  output logic                 exhausted
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]           state;
  logic [7:0]           start_pos;
  logic [7:0]           stride_q;
  logic [7:0]           cur [MAX_LEN];
  logic [7:0]           nxt [MAX_LEN];
  logic [MAX_LEN:0]     co;
  logic [MAX_LEN-1:0]   ci;
  logic [8*MAX_LEN-1:0] next_guess;
  logic                 last;
  logic                 start_ok;

  assign co[MAX_LEN] = 1'b0;

  // The last active position always steps; earlier ones step only on a carry.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_digit
    assign cur[i] = guess[8*(MAX_LEN-i)-1 -: 8];
    assign ci[i]  = (LEN_W'(i + 1) == guess_len) |
                    ((LEN_W'(i + 1) < guess_len) & co[i+1]);
    char_digit u_digit (
      .cur      (cur[i]),
      .stride   ((i == 0) ? stride_q : 8'd1),
      .reload   ((i == 0) ? start_pos : ASCII_A),
      .carry_in (ci[i]),
      .nxt      (nxt[i]),
      .carry_out(co[i])
    );
  end

  // On a length rollover the newly used trailing position starts at 'a'.
  always_comb begin
    next_guess = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      next_guess[8*(MAX_LEN-i)-1 -: 8] = nxt[i];
      if (co[0] && (LEN_W'(i) == guess_len))
        next_guess[8*(MAX_LEN-i)-1 -: 8] = ASCII_A;
    end
  end

  assign last     = co[0] && (guess_len == LEN_W'(MAX_LEN));
  assign start_ok = (starting_position >= ASCII_A) && (starting_position <= ASCII_Z);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      guess     <= '0;
      guess_len <= '0;
      exhausted <= 1'b0;
      start_pos <= ASCII_A;
      stride_q  <= 8'd1;
    end else begin
      case (state)
        S_RUN: begin
          if (found) begin
            state <= S_DONE;
          end else if (guess_ready) begin
            if (last) begin
              state     <= S_DONE;
              exhausted <= 1'b1;
            end else begin
              guess <= next_guess;
              if (co[0]) guess_len <= guess_len + LEN_W'(1);
            end
          end
        end
        default: begin
          if (start) begin
            start_pos <= starting_position;
            stride_q  <= (increment == 3'd0) ? 8'd1 : {5'd0, increment};
            if (start_ok) begin
              state                    <= S_RUN;
              guess                    <= '0;
              guess[8*MAX_LEN-1 -: 8]  <= starting_position;
              guess_len                <= LEN_W'(1);
              exhausted                <= 1'b0;
            end else begin
              state     <= S_DONE;
              exhausted <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign busy        = (state == S_RUN);
  assign guess_valid = busy;
endmodule

// File: tb/tb_md5_guess_generator.sv
// Randomized bench for md5_guess_generator against an index-based keyspace model.
module tb_md5_guess_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 0, found8 = 0, ready8 = 0;
  logic [7:0]  sp8 = 8'h61;
  logic [2:0]  inc8 = 3'd1;
  logic        valid8, busy8, exh8;
  logic [63:0] guess8;
  logic [3:0]  len8;

  logic        start2 = 0, found2 = 0, ready2 = 0;
  logic [7:0]  sp2 = 8'h61;
  logic [2:0]  inc2 = 3'd1;
  logic        valid2, busy2, exh2;
  logic [15:0] guess2;
  logic [1:0]  len2;

  int checks = 0;
  int failures = 0;

  md5_guess_generator #(.MAX_LEN(8), .LEN_W(4)) u_d8 (
    .clk(clk), .reset(rst), .start(start8), .starting_position(sp8), .increment(inc8),
    .found(found8), .guess_ready(ready8), .guess_valid(valid8), .guess(guess8),
    .guess_len(len8), .busy(busy8), .exhausted(exh8));

  md5_guess_generator #(.MAX_LEN(2), .LEN_W(2)) u_d2 (
    .clk(clk), .reset(rst), .start(start2), .starting_position(sp2), .increment(inc2),
    .found(found2), .guess_ready(ready2), .guess_valid(valid2), .guess(guess2),
    .guess_len(len2), .busy(busy2), .exhausted(exh2));

  // k-th guess of the keyspace: lengths in order, first char by stride, rest base-26.
  function automatic void model(input longint k, input int st, input int inc, input int maxlen,
                                output bit ok, output logic [127:0] g, output int len);
    int step;
    longint n0, pw, blk, rem;
    step = (inc == 0) ? 1 : inc;
    g = '0; ok = 0; len = 0;
    if (st < 'h61 || st > 'h7a) return;
    n0 = ('h7a - st) / step + 1;
    pw = 1;
    for (int l = 1; l <= maxlen; l++) begin
      blk = n0 * pw;
      if (k < blk) begin
        ok = 1; len = l;
        g[8*maxlen-1 -: 8] = 8'(st + step * (k / pw));
        rem = k % pw;
        for (int p = l - 1; p >= 1; p--) begin
          g[8*(maxlen-p)-1 -: 8] = 8'('h61 + rem % 26);
          rem = rem / 26;
        end
        return;
      end
      k = k - blk;
      pw = pw * 26;
    end
  endfunction

  function automatic longint model_total(input int st, input int inc, input int maxlen);
    int step;
    longint n0, pw, t;
    step = (inc == 0) ? 1 : inc;
    if (st < 'h61 || st > 'h7a) return 0;
    n0 = ('h7a - st) / step + 1;
    pw = 1; t = 0;
    for (int l = 1; l <= maxlen; l++) begin
      t = t + n0 * pw;
      pw = pw * 26;
    end
    return t;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid8, busy8, exh8} !== 3'b000 || guess8 !== 64'd0 || len8 !== 4'd0) begin
      failures++;
      $display("FAIL reset8 valid=%b busy=%b exh=%b guess=%h len=%0d want all zero",
               valid8, busy8, exh8, guess8, len8);
    end
    checks++;
    if ({valid2, busy2, exh2} !== 3'b000 || guess2 !== 16'd0 || len2 !== 2'd0) begin
      failures++;
      $display("FAIL reset2 valid=%b busy=%b exh=%b guess=%h len=%0d want all zero",
               valid2, busy2, exh2, guess2, len2);
    end
  endtask

  task automatic test_order8();
    bit ok; logic [127:0] g; int l;
    sp8 = 8'h61; inc8 = 3'd1; start8 = 1; ready8 = 1;
    @(negedge clk);
    start8 = 0;
    for (int k = 0; k < 30; k++) begin
      model(k, 'h61, 1, 8, ok, g, l);
      checks++;
      if (!ok || valid8 !== 1'b1 || guess8 !== g[63:0] || len8 !== 4'(l)) begin
        failures++;
        $display("FAIL order8 idx=%0d valid=%b guess=%h len=%0d want valid=1 guess=%h len=%0d",
                 k, valid8, guess8, len8, g[63:0], l);
      end
      @(negedge clk);
    end
    found8 = 1;
    @(negedge clk);
    found8 = 0;
  endtask

  task automatic test_exhaust2();
    int sp_t [3] = '{'h62, 'h61, 'h61};
    int inc_t[3] = '{2, 3, 0};
    int n_t  [3] = '{351, 243, 702};
    bit ok; logic [127:0] g; int l; int cnt; int cyc;
    for (int c = 0; c < 3; c++) begin
      sp2 = 8'(sp_t[c]); inc2 = 3'(inc_t[c]); start2 = 1; ready2 = 1;
      @(negedge clk);
      start2 = 0;
      cnt = 0; cyc = 0;
      while (valid2 === 1'b1 && cyc < 2000) begin
        model(cnt, sp_t[c], inc_t[c], 2, ok, g, l);
        checks++;
        if (!ok || guess2 !== g[15:0] || len2 !== 2'(l) || exh2 !== 1'b0) begin
          failures++;
          $display("FAIL exhaust2 cfg=%0d idx=%0d guess=%h len=%0d exh=%b want guess=%h len=%0d exh=0",
                   c, cnt, guess2, len2, exh2, g[15:0], l);
        end
        cnt++; cyc++;
        @(negedge clk);
      end
      checks++;
      if (cnt != n_t[c] || exh2 !== 1'b1 || busy2 !== 1'b0) begin
        failures++;
        $display("FAIL exhaust2_count cfg=%0d transfers=%0d exh=%b busy=%b want transfers=%0d exh=1 busy=0",
                 c, cnt, exh2, busy2, n_t[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; logic [127:0] g; int l; int cnt; int cyc; int sp; int inc;
    bit held; logic [15:0] pg; logic [1:0] pl;
    sp = 'h61 + $urandom_range(0, 25); inc = $urandom_range(0, 7);
    sp2 = 8'(sp); inc2 = 3'(inc); start2 = 1; ready2 = 0;
    @(negedge clk);
    start2 = 0;
    cnt = 0; cyc = 0; held = 0; pg = '0; pl = '0;
    while (valid2 === 1'b1 && cyc < 4000) begin
      if (held) begin
        checks++;
        if (guess2 !== pg || len2 !== pl) begin
          failures++;
          $display("FAIL hold guess=%h len=%0d want guess=%h len=%0d", guess2, len2, pg, pl);
        end
      end
      ready2 = 1'($urandom_range(0, 1));
      if (ready2) begin
        model(cnt, sp, inc, 2, ok, g, l);
        checks++;
        if (!ok || guess2 !== g[15:0] || len2 !== 2'(l)) begin
          failures++;
          $display("FAIL bp_seq idx=%0d guess=%h len=%0d want guess=%h len=%0d",
                   cnt, guess2, len2, g[15:0], l);
        end
        cnt++;
      end
      held = !ready2; pg = guess2; pl = len2;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (longint'(cnt) != model_total(sp, inc, 2) || exh2 !== 1'b1) begin
      failures++;
      $display("FAIL bp_count transfers=%0d exh=%b want transfers=%0d exh=1",
               cnt, exh2, model_total(sp, inc, 2));
    end
    ready2 = 0;
  endtask

  task automatic test_found();
    bit ok; logic [127:0] g; int l;
    sp8 = 8'h61; inc8 = 3'd1; start8 = 1; ready8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (27) @(negedge clk);
    model(27, 'h61, 1, 8, ok, g, l);
    checks++;
    if (valid8 !== 1'b1 || guess8 !== g[63:0]) begin
      failures++;
      $display("FAIL found_pre guess=%h valid=%b want guess=%h valid=1", guess8, valid8, g[63:0]);
    end
    found8 = 1;
    @(negedge clk);
    found8 = 0;
    checks++;
    if (valid8 !== 1'b0 || busy8 !== 1'b0 || exh8 !== 1'b0 || guess8 !== g[63:0]) begin
      failures++;
      $display("FAIL found_stop valid=%b busy=%b exh=%b guess=%h want 0 0 0 guess=%h",
               valid8, busy8, exh8, guess8, g[63:0]);
    end
    sp8 = 8'h63; start8 = 1;
    @(negedge clk);
    start8 = 0;
    checks++;
    if (valid8 !== 1'b1 || guess8 !== 64'h6300_0000_0000_0000 || len8 !== 4'd1) begin
      failures++;
      $display("FAIL found_restart valid=%b guess=%h len=%0d want valid=1 guess=6300000000000000 len=1",
               valid8, guess8, len8);
    end
    found8 = 1;
    @(negedge clk);
    found8 = 0;
  endtask

  task automatic test_random8();
    bit ok; logic [127:0] g; int l; int sp; int inc;
    for (int r = 0; r < 3; r++) begin
      sp = 'h61 + $urandom_range(0, 25); inc = $urandom_range(0, 7);
      sp8 = 8'(sp); inc8 = 3'(inc); start8 = 1; ready8 = 1;
      @(negedge clk);
      start8 = 0;
      for (int k = 0; k < 80; k++) begin
        model(k, sp, inc, 8, ok, g, l);
        checks++;
        if (!ok || valid8 !== 1'b1 || guess8 !== g[63:0] || len8 !== 4'(l)) begin
          failures++;
          $display("FAIL random8 sp=%h inc=%0d idx=%0d guess=%h len=%0d want guess=%h len=%0d",
                   sp, inc, k, guess8, len8, g[63:0], l);
        end
        @(negedge clk);
      end
      found8 = 1;
      @(negedge clk);
      found8 = 0;
    end
  endtask

  task automatic test_invalid_start();
    sp2 = 8'h7B; inc2 = 3'd1; start2 = 1; ready2 = 1;
    @(negedge clk);
    start2 = 0;
    checks++;
    if (valid2 !== 1'b0 || busy2 !== 1'b0 || exh2 !== 1'b1) begin
      failures++;
      $display("FAIL invalid_start valid=%b busy=%b exh=%b want 0 0 1", valid2, busy2, exh2);
    end
    sp2 = 8'h61; start2 = 1;
    @(negedge clk);
    start2 = 0;
    checks++;
    if (valid2 !== 1'b1 || exh2 !== 1'b0 || guess2 !== 16'h6100 || len2 !== 2'd1) begin
      failures++;
      $display("FAIL restart_clears valid=%b exh=%b guess=%h len=%0d want 1 0 6100 1",
               valid2, exh2, guess2, len2);
    end
    found2 = 1;
    @(negedge clk);
    found2 = 0; ready2 = 0;
  endtask

  task automatic test_reset_async();
    sp8 = 8'h61; inc8 = 3'd1; start8 = 1; ready8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({valid8, busy8, exh8} !== 3'b000 || guess8 !== 64'd0 || len8 !== 4'd0) begin
      failures++;
      $display("FAIL async_reset valid=%b busy=%b exh=%b guess=%h len=%0d want all zero",
               valid8, busy8, exh8, guess8, len8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (valid8 !== 1'b0 || guess8 !== 64'd0) begin
      failures++;
      $display("FAIL post_reset valid=%b guess=%h want 0 0", valid8, guess8);
    end
  endtask

  initial begin
    test_reset();
    test_order8();
    test_exhaust2();
    test_backpressure();
    test_found();
    test_random8();
    test_invalid_start();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/md5_guess_generator.md
# md5_guess_generator

Upstream candidate source for the MD5 cracking controller. It enumerates lowercase ASCII password guesses in a fixed, deterministic order, starting with first character `starting_position` and stepping that first character by `increment`, so several controllers can split the keyspace. Each guess, with its byte length, goes to the controller's hashing stage over a valid/ready handshake. Enumeration stops when the controller reports a match or the keyspace is exhausted.

## Interface
- MAX_LEN, 8, maximum guess length in characters (1..16)
- LEN_W, $clog2(MAX_LEN+1), width of `guess_len`
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; latches config and begins enumeration (ignored in RUN)
- starting_position  in  8  ASCII first character of the first guess of each length
- increment  in  3  stride of the first character; 0 is treated as 1
- found  in  1  downstream hash matched; stop immediately
- guess_ready  in  1  downstream accepts guess this cycle
- guess_valid  out  1  `guess`/`guess_len` hold a valid candidate
- guess  out  8*MAX_LEN  candidate, first char in MS byte, unused trailing bytes 0x00
- guess_len  out  LEN_W  characters in `guess` (1..MAX_LEN)
- busy  out  1  state is RUN
- exhausted  out  1  keyspace finished without `found`; sticky until start/reset

## Operation
- Character positions: c[0] (first, MS byte) .. c[L-1] (last). Valid range is 'a'(0x61)..'z'(0x7A).
- Odometer: c[L-1] increments fastest. Wrapping 'z' to 'a' carries into the next position toward c[1]. A carry into c[0] adds `increment`.
- If c[0]+increment > 'z', the length rolls over: L = L+1, c[0] = starting_position, c[1..L-1] = 'a'.
- If that rollover would give L > MAX_LEN, the generator goes to DONE and sets `exhausted`.
- Arithmetic for c[0] is 8-bit with a 9th carry bit, so there is no wrap past 0xFF.
- States:
  - IDLE: outputs low. On `start`, latch config and go to RUN with L=1, c[0]=starting_position. If starting_position is not in 'a'..'z', go to DONE with `exhausted`=1.
  - RUN: `guess_valid`=1.
  - DONE: `guess_valid`=0, `guess` retained. On `start`, restart as from IDLE.
- In RUN, a transfer (`guess_valid` & `guess_ready`) advances to the next guess in the same edge. Throughput is one guess per cycle.
- `found` has priority over a simultaneous transfer and over exhaustion. When high in RUN, the next state is DONE and `exhausted` stays 0.
- Without a transfer, `guess` and `guess_len` stay stable (AXI-style hold).
- `start` in RUN is ignored. `found` in IDLE or DONE is ignored.

## Timing
- Reset values:
  - `guess_valid`=0
  - `guess`=0
  - `guess_len`=0
  - `busy`=0
  - `exhausted`=0
  - state IDLE
- Reset is asynchronous, so asserting `reset` mid-run clears the block immediately with no further transfer.
- `start` sampled at edge N: the first guess is valid after edge N, for a 1-cycle latency.
- Transfer at edge N: the next guess is valid after edge N, or `guess_valid` falls after edge N if it was the last.
- `found` sampled at edge N: `guess_valid`=0 and `busy`=0 after edge N.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `md5_pkg`:
  - ASCII_A = 8'h61 and ASCII_Z = 8'h7A
  - state enum {IDLE, RUN, DONE}
  - the MAX_LEN default, shared with the controller
- Natural sub-module: `char_digit`, one odometer position that takes a step and a carry-in and produces the character and a carry-out. Instantiate MAX_LEN times.
- Position 0 uses a stride of `increment` and a reload value of `starting_position`. All other positions use a stride of 1 and a reload value of 'a'.

## Test plan
- MAX_LEN=8, start 'a', inc 1, ready always 1 -> transfers "a".."z", then 27th = "aa" (len 2), 28th = "ab"; no bubbles.
- MAX_LEN=2, start 'b', inc 2 -> length-1 guesses b,d,..,z (13). First length-2 guess is "ba". `exhausted`=1 after exactly 13+13*26=351 transfers.
- MAX_LEN=2, start 'a', inc 3 -> 9+234=243 transfers, then `exhausted`. inc 0 behaves exactly as inc 1 (702 transfers).
- Backpressure: toggle `guess_ready` randomly -> `guess` stable while valid & !ready; transferred sequence identical to the ready=1 run.
- `found` asserted together with a transfer of "ab" -> after that edge `guess_valid`=0, `busy`=0, `exhausted`=0. A new `start` restarts at starting_position.
- Assert `reset` mid-run -> all outputs 0 asynchronously. starting_position='{' (0x7B) with start -> DONE, `exhausted`=1, no transfer.
